// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
//   Multiply/divide unit beside the EX-stage ALU. Owns the HI/LO registers and
//   runs multi-cycle MULT/MULTU (fixed latency MUL_LAT) and DIV/DIVU (restoring
//   shift-subtract, WIDTH+1 cycles). MTHI/MTLO write HI/LO in a single edge.
//
//   Optional feature macro: ALU_MULDIV_MADD_EN
//     When defined, op codes 0110..1001 (MADD/MADDU/MSUB/MSUBU) accumulate the
//     product into {hi,lo} at the final multiply edge. When undefined, those
//     codes are no-ops and the accumulate adder is not built.
//
//   Parameters
//     WIDTH    operand and HI/LO width (even, >= 8)
//     MUL_LAT  cycles busy stays high for a multiply (1..63)
//
//   Ports
//     clk      clock, rising edge
//     reset_n  asynchronous active-low reset
//     start    request strobe, sampled only while busy is low
//     op       operation code
//     A        rs operand / dividend / MTHI-MTLO source
//     B        rt operand / divisor
//     busy     multi-cycle operation in flight
//     hi, lo   HI and LO registers
// -----------------------------------------------------------------------------
module alu_muldiv #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // One counter serves both the multiply latency and the divide bit count.
    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DIV_FIX
    } state_e;

    typedef enum logic [3:0] {
        OP_MULT  = 4'b0000,
        OP_MULTU = 4'b0001,
        OP_DIV   = 4'b0010,
        OP_DIVU  = 4'b0011,
        OP_MTHI  = 4'b0100,
        OP_MTLO  = 4'b0101,
        OP_MADD  = 4'b0110,
        OP_MADDU = 4'b0111,
        OP_MSUB  = 4'b1000,
        OP_MSUBU = 4'b1001
    } op_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    // Dividend bits leave the top of quo_q while quotient bits enter the bottom.
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
`ifdef ALU_MULDIV_MADD_EN
    logic               acc_q, acc_d;
    logic               sub_q, sub_d;
    logic [2*WIDTH-1:0] hilo;
`endif

    logic               mul_sgn;
    logic               div_sgn;
    logic [2*WIDTH-1:0] a_ext, b_ext, product;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     rem_sh, trial;

    // Operand conditioning and the divide datapath step.
    always_comb begin
        mul_sgn = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        div_sgn = (op == OP_DIV);
        // Extending to 2*WIDTH first makes one unsigned multiplier serve both
        // signednesses: the low 2*WIDTH bits of the product are exact.
        a_ext   = mul_sgn ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        b_ext   = mul_sgn ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
        product = a_ext * b_ext;
        // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is still correct unsigned.
        a_abs   = (div_sgn && A[WIDTH-1]) ? -A : A;
        b_abs   = (div_sgn && B[WIDTH-1]) ? -B : B;
        // The shifted remainder needs one extra bit before the trial subtract.
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, dvs_q};
    end

`ifdef ALU_MULDIV_MADD_EN
    assign hilo = {hi_q, lo_q};
`endif

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef ALU_MULDIV_MADD_EN
        acc_d     = acc_q;
        sub_d     = sub_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            prod_d  = product;
                            cnt_d   = CW'(MUL_LAT);
                            state_d = S_MUL;
`ifdef ALU_MULDIV_MADD_EN
                            acc_d   = 1'b0;
                            sub_d   = 1'b0;
`endif
                        end
`ifdef ALU_MULDIV_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            prod_d  = product;
                            cnt_d   = CW'(MUL_LAT);
                            state_d = S_MUL;
                            acc_d   = 1'b1;
                            sub_d   = (op == OP_MSUB) || (op == OP_MSUBU);
                        end
`endif
                        OP_DIV, OP_DIVU: begin
                            quo_d     = a_abs;
                            dvs_d     = b_abs;
                            rem_d     = '0;
                            neg_quo_d = div_sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_rem_d = div_sgn && A[WIDTH-1];
                            div0_d    = (B == '0);
                            cnt_d     = CW'(WIDTH);
                            state_d   = S_DIV;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef ALU_MULDIV_MADD_EN
                    if (acc_q) begin
                        {hi_d, lo_d} = sub_q ? (hilo - prod_q) : (hilo + prod_q);
                    end else begin
                        {hi_d, lo_d} = prod_q;
                    end
`else
                    {hi_d, lo_d} = prod_q;
`endif
                    state_d = S_IDLE;
                end
            end

            S_DIV: begin
                cnt_d = cnt_q - CW'(1);
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_DIV_FIX;
                end
            end

            S_DIV_FIX: begin
                // A zero divisor leaves the full dividend magnitude in the
                // remainder, so re-applying the dividend sign returns A in hi.
                lo_d    = div0_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef ALU_MULDIV_MADD_EN
            acc_q     <= 1'b0;
            sub_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef ALU_MULDIV_MADD_EN
            acc_q     <= acc_d;
            sub_q     <= sub_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv
//   Self-checking bench for alu_muldiv (WIDTH=32, MUL_LAT=5). A table of
//   directed vectors with hand-computed HI/LO and latency is applied in a loop,
//   followed by hand-written sequences for start-while-busy, back-to-back
//   issue and asynchronous reset in the middle of a divide.
// -----------------------------------------------------------------------------
module tb_alu_muldiv;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
    localparam logic [3:0] OP_MADDU = 4'b0111;
    localparam logic [3:0] OP_MSUB  = 4'b1000;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    localparam int MUL_CYC = 5;
    localparam int DIV_CYC = 33;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'b0;
    logic [31:0] A = 32'b0;
    logic [31:0] B = 32'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    // Bench-side record of what HI/LO must hold before the next operation.
    logic [31:0] exp_hi_prev = 32'h0;
    logic [31:0] exp_lo_prev = 32'h0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    alu_muldiv #(
        .WIDTH  (32),
        .MUL_LAT(5)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic [3:0] o, input logic [31:0] a, b,
                           input int lat, input logic [31:0] eh, el);
        vec_t v;
        v.name   = n;
        v.op     = o;
        v.a      = a;
        v.b      = b;
        v.lat    = lat;
        v.exp_hi = eh;
        v.exp_lo = el;
        vecs.push_back(v);
    endtask

    // Issue one op, scramble the operands after the accept edge, then count
    // edges until busy falls and compare latency, hold behaviour and result.
    task automatic run_vec(input vec_t v);
        int cyc;
        bit held;
        held = 1'b1;
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        A     = v.a;
        B     = v.b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = ~v.a;
        B     = ~v.b;
        check({v.name, " busy after accept"}, {31'b0, busy}, {31'b0, (v.lat > 0)});
        cyc = 0;
        while (busy && cyc < 200) begin
            if (hi !== exp_hi_prev || lo !== exp_lo_prev) held = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({v.name, " latency"}, cyc, v.lat);
        if (v.lat > 0) check({v.name, " hold"}, {31'b0, held}, 32'd1);
        check({v.name, " hi"}, hi, v.exp_hi);
        check({v.name, " lo"}, lo, v.exp_lo);
        exp_hi_prev = v.exp_hi;
        exp_lo_prev = v.exp_lo;
    endtask

    initial begin
        int  cyc;
        bit  held;
        vec_t post;

        add_vec("mult_neg2x3",  OP_MULT,  32'hFFFFFFFE, 32'd3,        MUL_CYC, 32'hFFFFFFFF, 32'hFFFFFFFA);
        add_vec("multu_fffex3", OP_MULTU, 32'hFFFFFFFE, 32'd3,        MUL_CYC, 32'h00000002, 32'hFFFFFFFA);
        add_vec("div_m7_2",     OP_DIV,   32'hFFFFFFF9, 32'd2,        DIV_CYC, 32'hFFFFFFFF, 32'hFFFFFFFD);
        add_vec("divu_100_7",   OP_DIVU,  32'd100,      32'd7,        DIV_CYC, 32'h00000002, 32'h0000000E);
        add_vec("divu_by0",     OP_DIVU,  32'h00001234, 32'd0,        DIV_CYC, 32'h00001234, 32'hFFFFFFFF);
        add_vec("div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_CYC, 32'h00000000, 32'h80000000);
        add_vec("div_7_m2",     OP_DIV,   32'd7,        32'hFFFFFFFE, DIV_CYC, 32'h00000001, 32'hFFFFFFFD);
        add_vec("div_m7_by0",   OP_DIV,   32'hFFFFFFF9, 32'd0,        DIV_CYC, 32'hFFFFFFF9, 32'hFFFFFFFF);
        add_vec("mthi",         OP_MTHI,  32'hDEADBEEF, 32'd0,        0,       32'hDEADBEEF, 32'hFFFFFFFF);
        add_vec("mtlo",         OP_MTLO,  32'h12345678, 32'd0,        0,       32'hDEADBEEF, 32'h12345678);
        add_vec("mult_min_min", OP_MULT,  32'h80000000, 32'h80000000, MUL_CYC, 32'h40000000, 32'h00000000);
        add_vec("multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_CYC, 32'hFFFFFFFE, 32'h00000001);
        add_vec("nop_op",       OP_NOP,   32'hCAFEF00D, 32'h1,        0,       32'hFFFFFFFE, 32'h00000001);
        add_vec("divu_max_1",   OP_DIVU,  32'hFFFFFFFF, 32'd1,        DIV_CYC, 32'h00000000, 32'hFFFFFFFF);
        add_vec("mthi_0",       OP_MTHI,  32'h00000000, 32'd0,        0,       32'h00000000, 32'hFFFFFFFF);
        add_vec("mtlo_ones",    OP_MTLO,  32'hFFFFFFFF, 32'd0,        0,       32'h00000000, 32'hFFFFFFFF);
`ifdef ALU_MULDIV_MADD_EN
        add_vec("maddu_1x1",    OP_MADDU, 32'd1,        32'd1,        MUL_CYC, 32'h00000001, 32'h00000000);
        add_vec("msub_1x1",     OP_MSUB,  32'd1,        32'd1,        MUL_CYC, 32'h00000000, 32'hFFFFFFFF);
`else
        add_vec("maddu_nop",    OP_MADDU, 32'd1,        32'd1,        0,       32'h00000000, 32'hFFFFFFFF);
        add_vec("msub_nop",     OP_MSUB,  32'd1,        32'd1,        0,       32'h00000000, 32'hFFFFFFFF);
`endif

        // Reset state.
        #1 reset_n = 1'b0;
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // start during MUL must be ignored: an MTHI pulse cannot disturb hi.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; A = 32'd2; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; A = 32'h0000AAAA;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored mthi busy", {31'b0, busy}, 32'd1);
        check("ignored mthi hi", hi, exp_hi_prev);
        cyc = 1;
        while (busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ignored mthi latency", cyc, MUL_CYC);
        check("ignored mthi result hi", hi, 32'h0);
        check("ignored mthi result lo", lo, 32'h6);

        // DIV with start held and operands changing every cycle, then MTLO
        // issued in the cycle busy falls.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; A = 32'hFFFFFFF9; B = 32'd2;
        @(posedge clk); #1;
        cyc  = 0;
        held = 1'b1;
        while (busy && cyc < 200) begin
            if (hi !== 32'h0 || lo !== 32'h6) held = 1'b0;
            @(negedge clk);
            A = $urandom;
            B = $urandom;
            @(posedge clk); #1;
            cyc++;
        end
        check("held start latency", cyc, DIV_CYC);
        check("held start hold", {31'b0, held}, 32'd1);
        check("held start hi", hi, 32'hFFFFFFFF);
        check("held start lo", lo, 32'hFFFFFFFD);
        op = OP_MTLO;
        A  = 32'h00000055;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b mtlo lo", lo, 32'h00000055);
        check("b2b mtlo hi", hi, 32'hFFFFFFFF);
        check("b2b mtlo busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst hi", hi, 32'h0);
        check("midrst lo", lo, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        held = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || hi !== 32'h0 || lo !== 32'h0) held = 1'b0;
        end
        check("midrst result discarded", {31'b0, held}, 32'd1);

        // The unit works normally after the mid-operation reset.
        exp_hi_prev = 32'h0;
        exp_lo_prev = 32'h0;
        post.name   = "post_reset_multu";
        post.op     = OP_MULTU;
        post.a      = 32'h00010000;
        post.b      = 32'h00010000;
        post.lat    = MUL_CYC;
        post.exp_hi = 32'h00000001;
        post.exp_lo = 32'h00000000;
        run_vec(post);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
